// File: rtl/digit_scan_mux_pkg.sv
// Shared display helpers: index-width derivation and the default blank code,
// which the segment decoder renders as all segments off.
package digit_scan_mux_pkg;

   localparam int DISPLAY_DIGIT_W = 5;
   localparam logic [DISPLAY_DIGIT_W-1:0] BLANK_CODE_DEFAULT = '1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Width of an index over n items, never narrower than one bit.
   function automatic int sel_width(input int n);
      return (n < 2) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/digit_scan_mux_tick_gen.sv
// Free-running prescaler: counts 0..PRESCALE-1 and strobes tick on the last count.
module tick_gen
   import digit_scan_mux_pkg::*;
#(
   parameter int PRESCALE = 50000,
   parameter int PCNT_W   = sel_width(PRESCALE)
) (
   input  logic              clk,
   input  logic              rst,
   output logic [PCNT_W-1:0] pcnt,
   output logic              tick
);

   assign tick = (pcnt == PCNT_W'(PRESCALE - 1));

   always_ff @(posedge clk) begin
      if (rst)       pcnt <= '0;
      else if (tick) pcnt <= '0;
      else           pcnt <= pcnt + PCNT_W'(1);
   end

endmodule

// File: rtl/digit_scan_mux.sv
// Multi-digit display scanner with per-frame input snapshot, leading-zero
// blanking and dead time between digit slots.
module digit_scan_mux
   import digit_scan_mux_pkg::*;
#(
   parameter int                NUM_DIGITS = 4,
   parameter int                DIGIT_W    = 5,
   parameter int                PRESCALE   = 50000,
   parameter int                DEAD       = 2,
   parameter logic [DIGIT_W-1:0] BLANK_CODE = {DIGIT_W{1'b1}},
   parameter int                SEL_W      = sel_width(NUM_DIGITS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
   input  logic                          lz_blank,
   output logic [DIGIT_W-1:0]            bin_out,
   output logic [NUM_DIGITS-1:0]         anode_n,
   output logic [SEL_W-1:0]              sel_out,
   output logic                          frame_start
);

   localparam int PCNT_W = sel_width(PRESCALE);

   logic [PCNT_W-1:0]             pcnt;
   logic [PCNT_W-1:0]             pcnt_nx;
   logic                          tick;
   logic [SEL_W-1:0]              sel;
   logic [SEL_W-1:0]              sel_nx;
   logic                          wrap;
   logic [NUM_DIGITS*DIGIT_W-1:0] shadow;
   logic [NUM_DIGITS*DIGIT_W-1:0] shadow_nx;
   logic [DIGIT_W-1:0]            code_nx;
   logic                          blank_nx;
   logic                          dead_nx;
   logic                          upper_zero;
   logic [NUM_DIGITS-1:0]         anode_nx;

   tick_gen #(.PRESCALE(PRESCALE), .PCNT_W(PCNT_W)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .pcnt (pcnt),
      .tick (tick)
   );

   // Outputs are formed from next-state values so select, enable and code
   // all move on the same edge.
   always_comb begin
      pcnt_nx   = tick ? '0 : pcnt + PCNT_W'(1);
      wrap      = tick && (sel == SEL_W'(NUM_DIGITS - 1));
      sel_nx    = sel;
      if (tick) sel_nx = wrap ? '0 : sel + SEL_W'(1);
      shadow_nx = wrap ? digits_in : shadow;
      dead_nx   = (DEAD == 0) ? 1'b0 : (int'(pcnt_nx) < DEAD);

      code_nx    = '0;
      blank_nx   = 1'b0;
      upper_zero = 1'b0;
      anode_nx   = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (sel_nx == SEL_W'(i)) begin
            upper_zero = 1'b1;
            for (int j = i; j < NUM_DIGITS; j++)
               if (shadow_nx[j*DIGIT_W +: DIGIT_W] != '0) upper_zero = 1'b0;
            code_nx  = shadow_nx[i*DIGIT_W +: DIGIT_W];
            blank_nx = lz_blank && (i > 0) && upper_zero;
            if (!dead_nx) anode_nx[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel         <= '0;
         shadow      <= digits_in;
         bin_out     <= '0;
         anode_n     <= '1;
         frame_start <= 1'b0;
      end else begin
         sel         <= sel_nx;
         shadow      <= shadow_nx;
         bin_out     <= blank_nx ? BLANK_CODE : code_nx;
         anode_n     <= anode_nx;
         frame_start <= wrap;
      end
   end

   assign sel_out = sel;

endmodule
